pulse_generator: RTL and testbench
==================================

# pulse_generator

Programmable pulse-train transmitter, the transmit-side counterpart of the correlator's pulse counter. On a start request it emits a burst of N registered pulses on `out` with programmable high and low durations, counted in clock cycles, then signals completion. It drives stimulus and calibration pulses into counter and correlator inputs, so a counter fed by `out` must read exactly N after a burst.

## Interface
- `RESOLUTION`, 32: width of the pulse-count input and of the `pulses_sent` counter.
- `TIME_RES`, 16: width of the high and low duration inputs.

- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `stop`  in  1  abort request; sampled in HIGH and LOW.
- `n_pulses`  in  RESOLUTION  number of pulses in the burst; latched on accepted start.
- `high_cycles`  in  TIME_RES  high duration in cycles; latched on accepted start; 0 is treated as 1.
- `low_cycles`  in  TIME_RES  low duration between pulses in cycles; latched on accepted start; 0 is treated as 1.
- `out`  out  1  registered pulse output.
- `busy`  out  1  high while in HIGH or LOW.
- `done`  out  1  one-cycle strobe at burst end, whether the burst completes or is aborted.
- `pulses_sent`  out  RESOLUTION  number of rising edges emitted in the current or last burst.

## Operation
- States:
  - IDLE: `out`=0, `busy`=0.
  - HIGH: `out`=1.
  - LOW: `out`=0.
- IDLE, `start`=1, `n_pulses`≠0:
  - latch N, H=max(`high_cycles`,1) and L=max(`low_cycles`,1);
  - clear `pulses_sent`;
  - go to HIGH.
- IDLE, `start`=1, `n_pulses`=0:
  - stay in IDLE; no pulse is emitted;
  - `done` strobes on the next cycle;
  - `pulses_sent` is cleared to 0.
- HIGH:
  - a duration counter loads H-1 on entry and decrements each cycle;
  - `pulses_sent` increments on the cycle HIGH is entered;
  - at count 0: if `pulses_sent`==N go to IDLE and assert `done`, else go to LOW.
- LOW:
  - the duration counter loads L-1 on entry;
  - at count 0 go to HIGH.
- No trailing low phase follows the last pulse.
- `stop`=1 in HIGH or LOW:
  - next cycle: IDLE, `out`=0, `done`=1;
  - `pulses_sent` holds its value;
  - `stop` wins over any same-cycle transition.
- `start` while `busy` is ignored. Inputs changing mid-burst have no effect, because they are latched.
- `pulses_sent` saturates at 2^RESOLUTION-1. In practice it cannot exceed N.
- `reset` low at any time, including mid-burst:
  - immediately sets IDLE, `out`=0, `busy`=0, `done`=0, `pulses_sent`=0, and clears all latched values;
  - no `done` strobe is generated on reset.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, `pulses_sent`=0.
- Start accepted at edge k:
  - `out` and `busy` rise at edge k+1 (one cycle latency);
  - `pulses_sent`=1 from edge k+1.
- Pulse i (1-based) is high on edges k+1+(i-1)(H+L) through k+(i-1)(H+L)+H. The period is H+L.
- The final pulse falls at edge k+1+(N-1)(H+L)+H. On that same edge `busy` falls and `done` rises for exactly one cycle.
- Burst length from the start edge is (N-1)(H+L)+H+1 cycles.
- Back-to-back bursts:
  - `start` held high on the `done` cycle is accepted, since the block is then in IDLE;
  - `out` rises again one cycle later, giving a minimum gap of 1 low cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-burst: N=5, H=3, L=2 started, `reset` pulled low at the 2nd pulse → `out`=0, `busy`=0 and `pulses_sent`=0 immediately. Releasing `reset` with `start` low → block stays IDLE, no `done`.
- Basic burst: N=3, H=2, L=4 → `out` pattern 110000110000110 starting 1 cycle after start; `done` on the cycle after the last 1; `pulses_sent`=3. A pulse_counter on `out` reads 3.
- Degenerate values:
  - N=0 → no pulses, `done` one cycle after start, `busy` never high;
  - H=0, L=0, N=4 → treated as H=L=1, giving `out`=10101010 (8 cycles then `done`).
- Abort: N=10, H=L=5, `stop` asserted during the 3rd high phase → `out` low and `done` high the next cycle; `pulses_sent`=3; later `start` requests work normally.
- Ignored requests: `start` pulsed and `n_pulses` changed to 100 mid-burst of N=2 → exactly 2 pulses and one `done`. Back-to-back: `start` held high continuously with N=2, H=1, L=1 → `out`=1010 1010…, i.e. `out` 101 / 0 gap / 101 repeating, with `done` every 4 cycles.
- Wide count: RESOLUTION=8, N=255, H=L=1 → 255 pulses, `pulses_sent`=255, no wrap to 0 before `done`.

Source files
------------

// File: rtl/pulse_generator.sv
// Programmable pulse-train transmitter: emits N pulses of H high / L low cycles
// per start request, then strobes done. State advances on the accepting edge and
// every output is a register of that state, so outputs trail the FSM by one cycle.
module pulse_generator #(
  parameter int unsigned RESOLUTION = 32,
  parameter int unsigned TIME_RES   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [RESOLUTION-1:0] n_pulses,
  input  logic [TIME_RES-1:0]   high_cycles,
  input  logic [TIME_RES-1:0]   low_cycles,
  output logic                  out,
  output logic                  busy,
  output logic                  done,
  output logic [RESOLUTION-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

  state_t                state_q, state_d;
  logic [TIME_RES-1:0]   dur_q, dur_d;
  logic [RESOLUTION-1:0] cnt_q, cnt_d;
  logic [RESOLUTION-1:0] n_q, n_d;
  logic [TIME_RES-1:0]   hm1_q, hm1_d;
  logic [TIME_RES-1:0]   lm1_q, lm1_d;
  logic                  fin_q, fin_c;

  logic [TIME_RES-1:0]   hm1_c;
  logic [TIME_RES-1:0]   lm1_c;
  logic [RESOLUTION-1:0] cnt_inc_c;

  // Durations stored as (max(x,1) - 1) so the counter reloads directly.
  assign hm1_c     = (high_cycles == '0) ? '0 : high_cycles - TIME_RES'(1);
  assign lm1_c     = (low_cycles  == '0) ? '0 : low_cycles  - TIME_RES'(1);
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + RESOLUTION'(1);

  // FSM state and latched burst parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dur_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      hm1_q   <= '0;
      lm1_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      hm1_q   <= hm1_d;
      lm1_q   <= lm1_d;
      fin_q   <= fin_c;
    end
  end

  // Next-state logic; stop overrides any duration-driven transition.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    hm1_d   = hm1_q;
    lm1_d   = lm1_q;
    fin_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_pulses != '0) begin
            n_d     = n_pulses;
            hm1_d   = hm1_c;
            lm1_d   = lm1_c;
            dur_d   = hm1_c;
            cnt_d   = RESOLUTION'(1);
            state_d = HIGH;
          end else begin
            cnt_d = '0;
            fin_c = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          state_d = IDLE;
          fin_c   = 1'b1;
        end else if (dur_q == '0) begin
          if (cnt_q == n_q) begin
            state_d = IDLE;
            fin_c   = 1'b1;
          end else begin
            state_d = LOW;
            dur_d   = lm1_q;
          end
        end else begin
          dur_d = dur_q - TIME_RES'(1);
        end
      end
      LOW: begin
        if (stop) begin
          state_d = IDLE;
          fin_c   = 1'b1;
        end else if (dur_q == '0) begin
          state_d = HIGH;
          dur_d   = hm1_q;
          cnt_d   = cnt_inc_c;
        end else begin
          dur_d = dur_q - TIME_RES'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs derived from the current FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulses_sent <= '0;
    end else begin
      out         <= (state_q == HIGH);
      busy        <= (state_q != IDLE);
      done        <= fin_q;
      pulses_sent <= cnt_q;
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: hand-computed waveforms per scenario.
module tb_pulse_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [31:0] n_pulses;
  logic [15:0] high_cycles, low_cycles;
  logic        out, busy, done;
  logic [31:0] pulses_sent;

  logic        start8;
  logic [7:0]  n8;
  logic [15:0] h8, l8;
  logic        out8, busy8, done8;
  logic [7:0]  ps8;

  int total = 0;
  int bad   = 0;

  logic [31:0] pat;
  int          dn, rs;
  logic [31:0] pat2;
  int          dn2, rs2;
  logic [31:0] pat3;
  int          dn3, rs3;

  always #5 clk = ~clk;

  pulse_generator u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .n_pulses(n_pulses), .high_cycles(high_cycles), .low_cycles(low_cycles),
    .out(out), .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  pulse_generator #(.RESOLUTION(8), .TIME_RES(16)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .stop(1'b0),
    .n_pulses(n8), .high_cycles(h8), .low_cycles(l8),
    .out(out8), .busy(busy8), .done(done8), .pulses_sent(ps8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Shift out into a pattern for ncyc edges, counting done strobes and rising edges.
  task automatic run(input int ncyc, output logic [31:0] p, output int dones, output int rises);
    logic prev;
    p = '0; dones = 0; rises = 0; prev = out;
    for (int i = 0; i < ncyc; i++) begin
      step();
      p = {p[30:0], out};
      if (done) dones++;
      if (out && !prev) rises++;
      prev = out;
    end
  endtask

  initial begin
    int   cyc, r8;
    logic wrap, prev8;
    logic [7:0] prevps;

    reset = 1'b0; start = 1'b0; stop = 1'b0;
    n_pulses = '0; high_cycles = '0; low_cycles = '0;
    start8 = 1'b0; n8 = '0; h8 = '0; l8 = '0;
    step(); step();
    chk("rst_out",  32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ps",   pulses_sent, 32'd0);
    reset = 1'b1;
    step();

    // Basic burst N=3 H=2 L=4
    n_pulses = 32'd3; high_cycles = 16'd2; low_cycles = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    chk("basic_lat_out", 32'(out), 32'd0);
    step();
    chk("basic_first_out",  32'(out), 32'd1);
    chk("basic_first_busy", 32'(busy), 32'd1);
    chk("basic_first_ps",   pulses_sent, 32'd1);
    run(14, pat, dn, rs);
    chk("basic_pattern", pat, 32'b10000110000110);
    chk("basic_dones",   32'(dn), 32'd1);
    chk("basic_done_end", 32'(done), 32'd1);
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_ps",       pulses_sent, 32'd3);
    chk("basic_rises",    32'(rs + 1), 32'd3);
    step();
    chk("basic_done_1cyc", 32'(done), 32'd0);

    // N=0: done next cycle, no pulse, pulses_sent cleared
    n_pulses = 32'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("n0_done_early", 32'(done), 32'd0);
    run(1, pat, dn, rs);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_busy", 32'(busy), 32'd0);
    chk("n0_ps",   pulses_sent, 32'd0);
    run(3, pat, dn, rs);
    chk("n0_quiet", pat, 32'd0);
    chk("n0_nodone", 32'(dn), 32'd0);

    // H=0 L=0 N=4 behaves as H=L=1
    n_pulses = 32'd4; high_cycles = 16'd0; low_cycles = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    run(8, pat, dn, rs);
    chk("h0l0_pattern", pat, 32'b10101010);
    chk("h0l0_done",    32'(done), 32'd1);
    chk("h0l0_dones",   32'(dn), 32'd1);
    chk("h0l0_ps",      pulses_sent, 32'd4);
    step();

    // Abort during 3rd high phase of N=10 H=L=5
    n_pulses = 32'd10; high_cycles = 16'd5; low_cycles = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    run(22, pat, dn, rs);
    chk("abort_rises_before", 32'(rs), 32'd3);
    chk("abort_out_high", 32'(out), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    chk("abort_out",  32'(out), 32'd0);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ps",   pulses_sent, 32'd3);
    run(12, pat, dn, rs);
    chk("abort_quiet", pat, 32'd0);
    chk("abort_nodone", 32'(dn), 32'd0);

    // Requests during a burst are ignored: N=2 H=2 L=2
    n_pulses = 32'd2; high_cycles = 16'd2; low_cycles = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    run(2, pat, dn, rs);
    start = 1'b1; n_pulses = 32'd100;
    run(2, pat2, dn2, rs2);
    start = 1'b0;
    run(3, pat3, dn3, rs3);
    chk("ign_rises", 32'(rs + rs2 + rs3), 32'd2);
    chk("ign_dones", 32'(dn + dn2 + dn3), 32'd1);
    chk("ign_done_at_end", 32'(done), 32'd1);
    chk("ign_ps", pulses_sent, 32'd2);
    run(6, pat, dn, rs);
    chk("ign_quiet", pat, 32'd0);

    // Back-to-back with start held: N=2 H=1 L=1
    n_pulses = 32'd2; high_cycles = 16'd1; low_cycles = 16'd1; start = 1'b1;
    step();
    run(16, pat, dn, rs);
    chk("b2b_pattern", pat, 32'hAAAA);
    chk("b2b_dones",   32'(dn), 32'd4);
    start = 1'b0;
    run(8, pat, dn, rs);
    chk("b2b_tail_pattern", pat, 32'b10100000);
    chk("b2b_tail_dones", 32'(dn), 32'd1);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset mid-burst: N=5 H=3 L=2, pulled during 2nd pulse
    n_pulses = 32'd5; high_cycles = 16'd3; low_cycles = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    run(7, pat, dn, rs);
    chk("rstm_in_pulse2", 32'(out), 32'd1);
    chk("rstm_ps_before", pulses_sent, 32'd2);
    reset = 1'b0;
    #1;
    chk("rstm_out",  32'(out), 32'd0);
    chk("rstm_busy", 32'(busy), 32'd0);
    chk("rstm_done", 32'(done), 32'd0);
    chk("rstm_ps",   pulses_sent, 32'd0);
    step();
    reset = 1'b1;
    run(12, pat, dn, rs);
    chk("rstm_quiet", pat, 32'd0);
    chk("rstm_nodone", 32'(dn), 32'd0);
    chk("rstm_nobusy", 32'(busy), 32'd0);

    // Wide count on 8-bit instance: N=255 H=L=1, no wrap
    n8 = 8'd255; h8 = 16'd1; l8 = 16'd1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    cyc = 0; r8 = 0; wrap = 1'b0; prev8 = 1'b0; prevps = ps8;
    while (!done8 && cyc < 600) begin
      step();
      cyc++;
      if (ps8 < prevps) wrap = 1'b1;
      prevps = ps8;
      if (out8 && !prev8) r8++;
      prev8 = out8;
    end
    chk("wide_len",   32'(cyc), 32'd510);
    chk("wide_ps",    32'(ps8), 32'd255);
    chk("wide_rises", 32'(r8), 32'd255);
    chk("wide_nowrap", 32'(wrap), 32'd0);
    chk("wide_busy",  32'(busy8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
